// File: rtl/ssp_pkg.sv
// Shared definitions for the parametrised synchronous serial port.
// TX state encodings and the FIFO level-width helper.
package ssp_pkg;

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_FRAME = 2'd1;
    localparam logic [1:0] TX_SHIFT = 2'd2;

    // Level counters need one extra bit so that a full FIFO (DEPTH) is representable.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ssp_fifo.sv
// Synchronous FIFO with occupancy level; used for both TX and RX word queues.
// A push while full is accepted only when a pop happens on the same edge.
module ssp_fifo
    import ssp_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     PCLK,
    input  logic                     CLEAR,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [lvl_w(DEPTH)-1:0]  level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = lvl_w(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge PCLK) begin
        if (push_ok)
            mem[wr_ptr] <= din;
    end

    // Pointers are exactly log2(DEPTH) wide, so they wrap modulo DEPTH.
    always_ff @(posedge PCLK) begin
        if (CLEAR) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(push_ok) - LW'(pop_ok);
        end
    end

endmodule

// File: rtl/ssp_param.sv
// Parametrised synchronous serial port: host word FIFOs, frame-sync master
// transmitter and oversampling slave receiver, all clocked by PCLK.
module ssp_param
    import ssp_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int CLK_DIV   = 1,
    parameter int LSB_FIRST = 0
) (
    input  logic              PCLK,
    input  logic              CLEAR,
    input  logic              PSEL,
    input  logic              PWRITE,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    input  logic              SSPCLKIN,
    input  logic              SSPFSSIN,
    input  logic              SSPRXD,
    output logic              SSPCLKOUT,
    output logic              SSPFSSOUT,
    output logic              SSPTXD,
    output logic              SSPOE_B,
    output logic              SSPTXINTR,
    output logic              SSPRXINTR,
    output logic              SSPRXOVR
);

    localparam int LW   = lvl_w(DEPTH);
    localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW   = $clog2(DATA_W + 1);

    logic              tx_push, tx_pop, tx_full, tx_empty;
    logic [DATA_W-1:0] tx_dout;
    logic [LW-1:0]     tx_level;
    logic              rx_push, rx_pop, rx_full, rx_empty;
    logic [DATA_W-1:0] rx_dout;
    logic [LW-1:0]     rx_level;
    logic              rd_req;

    logic [DIVW-1:0]   div_cnt;
    logic              div_wrap, tick_r;

    logic [1:0]        tx_state;
    logic [DATA_W-1:0] tx_sh, tx_sh_next;
    logic              tx_bit;
    logic [CW-1:0]     tx_cnt;

    logic [1:0]        clk_s, fss_s, rxd_s;
    logic              clk_d, rx_fall;
    logic [CW-1:0]     rx_cnt;
    logic [DATA_W-1:0] rx_sh, rx_word;

    assign rd_req    = PSEL & ~PWRITE;
    assign rx_pop    = rd_req & ~rx_empty;
    assign tx_pop    = tick_r & (tx_state == TX_IDLE) & ~tx_empty;
    assign tx_push   = PSEL & PWRITE & (~tx_full | tx_pop);
    assign SSPTXINTR = (tx_level <= LW'(DEPTH / 2));
    assign SSPRXINTR = (rx_level >= LW'(DEPTH / 2));

    ssp_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
        .PCLK  (PCLK),
        .CLEAR (CLEAR),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (PWDATA),
        .dout  (tx_dout),
        .full  (tx_full),
        .empty (tx_empty),
        .level (tx_level)
    );

    ssp_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
        .PCLK  (PCLK),
        .CLEAR (CLEAR),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (rx_word),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty),
        .level (rx_level)
    );

    // Free-running divider; TX advances only when SSPCLKOUT rises.
    assign div_wrap = (div_cnt == DIVW'(CLK_DIV - 1));
    assign tick_r   = div_wrap & ~SSPCLKOUT;

    always_ff @(posedge PCLK) begin
        if (CLEAR) begin
            div_cnt   <= '0;
            SSPCLKOUT <= 1'b0;
        end else if (div_wrap) begin
            div_cnt   <= '0;
            SSPCLKOUT <= ~SSPCLKOUT;
        end else begin
            div_cnt   <= div_cnt + 1'b1;
        end
    end

    always_comb begin
        tx_bit     = (LSB_FIRST != 0) ? tx_sh[0] : tx_sh[DATA_W-1];
        tx_sh_next = (LSB_FIRST != 0) ? (tx_sh >> 1) : (tx_sh << 1);
    end

    always_ff @(posedge PCLK) begin
        if (CLEAR) begin
            tx_state  <= TX_IDLE;
            tx_sh     <= '0;
            tx_cnt    <= '0;
            SSPFSSOUT <= 1'b0;
            SSPTXD    <= 1'b0;
            SSPOE_B   <= 1'b1;
        end else if (tick_r) begin
            case (tx_state)
                TX_IDLE: begin
                    if (!tx_empty) begin
                        tx_sh     <= tx_dout;
                        SSPFSSOUT <= 1'b1;
                        tx_state  <= TX_FRAME;
                    end
                end
                TX_FRAME: begin
                    SSPFSSOUT <= 1'b0;
                    SSPOE_B   <= 1'b0;
                    SSPTXD    <= tx_bit;
                    tx_sh     <= tx_sh_next;
                    tx_cnt    <= CW'(DATA_W - 1);
                    tx_state  <= TX_SHIFT;
                end
                TX_SHIFT: begin
                    if (tx_cnt != '0) begin
                        SSPTXD <= tx_bit;
                        tx_sh  <= tx_sh_next;
                        tx_cnt <= tx_cnt - 1'b1;
                    end else begin
                        SSPOE_B  <= 1'b1;
                        SSPTXD   <= 1'b0;
                        tx_state <= TX_IDLE;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // All three serial inputs share the same synchroniser delay, so data and
    // frame sync stay aligned with the recovered clock edge.
    assign rx_fall = clk_d & ~clk_s[1];
    assign rx_word = (LSB_FIRST != 0) ? {rxd_s[1], rx_sh[DATA_W-1:1]}
                                      : {rx_sh[DATA_W-2:0], rxd_s[1]};
    assign rx_push = rx_fall & ~fss_s[1] & (rx_cnt == CW'(1));

    always_ff @(posedge PCLK) begin
        if (CLEAR) begin
            clk_s    <= '0;
            fss_s    <= '0;
            rxd_s    <= '0;
            clk_d    <= 1'b0;
            rx_cnt   <= '0;
            rx_sh    <= '0;
            PRDATA   <= '0;
            SSPRXOVR <= 1'b0;
        end else begin
            clk_s <= {clk_s[0], SSPCLKIN};
            fss_s <= {fss_s[0], SSPFSSIN};
            rxd_s <= {rxd_s[0], SSPRXD};
            clk_d <= clk_s[1];
            if (rx_fall) begin
                if (fss_s[1]) begin
                    rx_cnt <= CW'(DATA_W);
                end else if (rx_cnt != '0) begin
                    rx_sh  <= rx_word;
                    rx_cnt <= rx_cnt - 1'b1;
                end
            end
            if (rx_pop)
                PRDATA <= rx_dout;
            if (rx_push && rx_full && !rx_pop)
                SSPRXOVR <= 1'b1;
            else if (rd_req)
                SSPRXOVR <= 1'b0;
        end
    end

endmodule
